// File: rtl/sipo_pkg.sv
// Shared types for the serial-in/parallel-out deserializer: shift FSM states
// and the bit-order encodings used by the SHIFT_DIR parameter.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel output bundle for sipo_deser.
// overrun/overrun_clr exist only when SIPO_OVERRUN_EN is defined.
interface sipo_deser_if #(
  parameter int SIZE = 8
);
  logic            in;
  logic            in_valid;
  logic            clear;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
`ifdef SIPO_OVERRUN_EN
  logic            overrun;
  logic            overrun_clr;

  modport slave (
    input  in, in_valid, clear, out_ready, overrun_clr,
    output out_data, out_valid, busy, overrun
  );
  modport master (
    output in, in_valid, clear, out_ready, overrun_clr,
    input  out_data, out_valid, busy, overrun
  );
`else
  modport slave (
    input  in, in_valid, clear, out_ready,
    output out_data, out_valid, busy
  );
  modport master (
    output in, in_valid, clear, out_ready,
    input  out_data, out_valid, busy
  );
`endif
endinterface

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready output register. A new word is taken only when the
// slot is empty or being drained on the same edge; otherwise it is ignored.
module sipo_hold_reg #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic [SIZE-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [SIZE-1:0] data_o
);

  logic            valid_q, valid_d;
  logic [SIZE-1:0] data_q,  data_d;
  logic            accept;

  assign accept = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i && accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer with a one-word output hold register.
// Optional sticky dropped-word flag under SIPO_OVERRUN_EN.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int SHIFT_DIR = LSB_FIRST
) (
  input  logic         clk,
  input  logic         reset_n,
  sipo_deser_if.slave  bus
);

  localparam int CW = $clog2(SIZE);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] sh_q, sh_d;
  logic [CW-1:0]   idx;
  logic            done;

  // Bits are written in place by arrival index, so every word rewrites all
  // positions and an aborted word leaves no residue.
  assign idx = (SHIFT_DIR == MSB_FIRST) ? (CW'(SIZE - 1) - cnt_q) : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.in_valid) begin
      sh_d[idx] = bus.in;
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
        SHIFT: begin
          if (cnt_q == CW'(SIZE - 1)) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);

  sipo_hold_reg #(.SIZE(SIZE)) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (done),
    .data_i  (sh_d),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_data)
  );

`ifdef SIPO_OVERRUN_EN
  logic drop;
  logic ovr_q;

  assign drop = done && bus.out_valid && !bus.out_ready;

  // Set wins over clear so a drop coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             ovr_q <= 1'b0;
    else if (drop)            ovr_q <= 1'b1;
    else if (bus.overrun_clr) ovr_q <= 1'b0;
  end

  assign bus.overrun = ovr_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench: two DUTs (LSB-first and MSB-first) share stimulus; a
// negedge monitor pops expected words on every output handshake.
module tb_sipo_deser;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sipo_deser_if #(.SIZE(8)) b0 ();
  sipo_deser_if #(.SIZE(8)) b1 ();

  sipo_deser #(.SIZE(8), .SHIFT_DIR(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  sipo_deser #(.SIZE(8), .SHIFT_DIR(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  int total = 0;
  int bad   = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b0.out_valid === 1'b1 && b0.out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL lsb unexpected word: got %0h expected none", b0.out_data);
      end else chk("lsb word", {24'd0, b0.out_data}, {24'd0, q0.pop_front()});
    end
    if (b1.out_valid === 1'b1 && b1.out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL msb unexpected word: got %0h expected none", b1.out_data);
      end else chk("msb word", {24'd0, b1.out_data}, {24'd0, q1.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic c);
    b0.in_valid = v; b1.in_valid = v;
    b0.in       = b; b1.in       = b;
    b0.clear    = c; b1.clear    = c;
  endtask

  task automatic set_ready(input logic r);
    b0.out_ready = r; b1.out_ready = r;
  endtask

  task automatic expect_word(input logic [7:0] e0, input logic [7:0] e1);
    q0.push_back(e0); q1.push_back(e1);
  endtask

  // w[k] is the k-th bit on the wire; gap idle cycles follow each non-final bit.
  task automatic send_word(input logic [7:0] w, input int gap);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, w[k], 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0);
      if (k < 7) begin
        for (int g = 0; g < gap; g++) begin
          chk("busy in gap lsb", {31'd0, b0.busy}, 32'd1);
          chk("busy in gap msb", {31'd0, b1.busy}, 32'd1);
          step();
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    set_ready(1'b1);
`ifdef SIPO_OVERRUN_EN
    b0.overrun_clr = 1'b0; b1.overrun_clr = 1'b0;
`endif
    #12;
    chk("reset out_valid", {31'd0, b0.out_valid}, 32'd0);
    chk("reset out_data",  {24'd0, b0.out_data},  32'd0);
    chk("reset busy",      {31'd0, b0.busy},      32'd0);
`ifdef SIPO_OVERRUN_EN
    chk("reset overrun",   {31'd0, b0.overrun},   32'd0);
`endif
    step();
    reset_n = 1'b1;
    step();

    // bits 1,0,1,1,0,0,1,0 back to back
    expect_word(8'h4D, 8'hB2);
    send_word(8'h4D, 0);
    chk("valid after 8th bit", {31'd0, b0.out_valid}, 32'd1);
    chk("data after 8th bit lsb", {24'd0, b0.out_data}, 32'h4D);
    chk("data after 8th bit msb", {24'd0, b1.out_data}, 32'hB2);
    chk("busy after word", {31'd0, b0.busy}, 32'd0);
    step();
    chk("valid one cycle only", {31'd0, b0.out_valid}, 32'd0);
    step();

    // same word with 3-cycle gaps
    expect_word(8'h4D, 8'hB2);
    send_word(8'h4D, 3);
    step(); step();

    // consumer stalled: second word is dropped
    set_ready(1'b0);
    expect_word(8'hA5, 8'hA5);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    step();
    chk("hold keeps first lsb", {24'd0, b0.out_data}, 32'hA5);
    chk("hold keeps first msb", {24'd0, b1.out_data}, 32'hA5);
    chk("hold still valid", {31'd0, b0.out_valid}, 32'd1);
`ifdef SIPO_OVERRUN_EN
    chk("overrun set", {31'd0, b0.overrun}, 32'd1);
    b0.overrun_clr = 1'b1; b1.overrun_clr = 1'b1;
    step();
    b0.overrun_clr = 1'b0; b1.overrun_clr = 1'b0;
    chk("overrun cleared", {31'd0, b0.overrun}, 32'd0);
`endif
    set_ready(1'b1);
    step(); step();
    chk("drained", {31'd0, b0.out_valid}, 32'd0);

    // abort after 5 bits, clear cycle also carries a bit that must be ignored
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    chk("busy before clear", {31'd0, b0.busy}, 32'd1);
    drive(1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    chk("busy after clear", {31'd0, b0.busy}, 32'd0);
    chk("clear leaves valid", {31'd0, b0.out_valid}, 32'd0);
    expect_word(8'h0F, 8'hF0);
    send_word(8'h0F, 0);
    step(); step();

    // async reset mid-word with a held output
    set_ready(1'b0);
    send_word(8'h55, 0);
    step();
    chk("held before reset", {31'd0, b0.out_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset valid", {31'd0, b0.out_valid}, 32'd0);
    chk("async reset data",  {24'd0, b0.out_data},  32'd0);
    chk("async reset busy",  {31'd0, b0.busy},      32'd0);
    chk("async reset msb data", {24'd0, b1.out_data}, 32'd0);
    step();
    reset_n = 1'b1;
    set_ready(1'b1);
    step();
    expect_word(8'h96, 8'h69);
    send_word(8'h96, 0);
    step(); step(); step();

    chk("lsb queue empty", q0.size(), 32'd0);
    chk("msb queue empty", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
